// File: rtl/time_mgr_pkg.sv
// Shared defaults, channel-state type and the wrap-aware time comparison for time_mgr_mc.
package time_mgr_pkg;

  localparam int DEF_NUNIT = 16;
  localparam int DEF_NTIME = 40;
  localparam int DEF_NCH   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chan_state_t;

  // Reached when (curr - tgt) mod 2^width has its top bit clear, i.e. curr is
  // at most half the time range past tgt. Valid for width 1..64.
  function automatic logic time_reached(input logic [63:0] curr,
                                        input logic [63:0] tgt,
                                        input int          width);
    logic [63:0] diff;
    logic [5:0]  msb;
    diff = curr - tgt;
    msb  = 6'(width - 1);
    return !diff[msb];
  endfunction

endpackage

// File: rtl/time_wait_chan.sv
// One stream channel: latches a target time, then pulses release once the target is reached.
// Release is registered one cycle after the reached condition; accept is high only while idle.
module time_wait_chan
  import time_mgr_pkg::*;
#(
  parameter int NTIME = DEF_NTIME
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reset_time,
  input  logic             time_v,
  output logic             time_a,
  input  logic [NTIME-1:0] time_target,
  input  logic [NTIME-1:0] curr_time,
  output logic             release_pulse
);

  chan_state_t      state, state_nxt;
  logic [NTIME-1:0] target, target_nxt;
  logic             rel_nxt;
  logic             reached;

  assign reached = time_reached(64'(curr_time), 64'(target), NTIME);
  assign time_a  = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      target        <= '0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      target        <= target_nxt;
      release_pulse <= rel_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    rel_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (time_v) begin
          target_nxt = time_target;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        // A time reset abandons the wait silently.
        if (reset_time) begin
          state_nxt = IDLE;
        end else if (reached) begin
          rel_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/time_mgr_mc.sv
// Time-unit counter plus NCH independent target-time release channels; release is registered.
// Optional heartbeat (define TIME_MGR_HEARTBEAT_EN) is held until hb_a; one due while pending is dropped.
module time_mgr_mc
  import time_mgr_pkg::*;
#(
  parameter int NUNIT   = DEF_NUNIT,
  parameter int NTIME   = DEF_NTIME,
  parameter int NCH     = DEF_NCH,
  parameter int HB_LOG2 = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reset_time,
  input  logic [NUNIT-1:0]     unit_len,
  input  logic [NCH-1:0]       pc_time_v,
  output logic [NCH-1:0]       pc_time_a,
  input  logic [NCH*NTIME-1:0] pc_time_elapsed,
  // 'release' is a reserved word, hence the suffix.
  output logic [NCH-1:0]       release_pulse,
  output logic                 unit_tick,
  output logic [NTIME-1:0]     curr_time
`ifdef TIME_MGR_HEARTBEAT_EN
  ,
  output logic                 hb_v,
  input  logic                 hb_a,
  output logic [NTIME-1:0]     hb_time
`endif
);

  logic [NUNIT-1:0] unit_cnt;
  logic             unit_end;

  // Widened compare so unit_len of 0 or 1 ends every cycle, and a shrunken
  // unit_len ends the unit at once.
  assign unit_end = ({1'b0, unit_cnt} + 1'b1) >= {1'b0, unit_len};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unit_cnt  <= '0;
      curr_time <= '0;
      unit_tick <= 1'b0;
    end else if (reset_time) begin
      unit_cnt  <= '0;
      curr_time <= '0;
      unit_tick <= 1'b0;
    end else if (unit_end) begin
      unit_cnt  <= '0;
      curr_time <= curr_time + 1'b1;
      unit_tick <= 1'b1;
    end else begin
      unit_cnt  <= unit_cnt + 1'b1;
      unit_tick <= 1'b0;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    time_wait_chan #(
      .NTIME(NTIME)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .reset_time   (reset_time),
      .time_v       (pc_time_v[c]),
      .time_a       (pc_time_a[c]),
      .time_target  (pc_time_elapsed[c*NTIME +: NTIME]),
      .curr_time    (curr_time),
      .release_pulse(release_pulse[c])
    );
  end

`ifdef TIME_MGR_HEARTBEAT_EN
  logic [NTIME-1:0] time_next;
  logic             hb_due;

  assign time_next = curr_time + 1'b1;
  assign hb_due    = unit_end && (time_next[HB_LOG2-1:0] == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hb_v    <= 1'b0;
      hb_time <= '0;
    end else if (reset_time) begin
      hb_v <= 1'b0;
    end else if (hb_due && (!hb_v || hb_a)) begin
      hb_v    <= 1'b1;
      hb_time <= time_next;
    end else if (hb_a) begin
      hb_v <= 1'b0;
    end
  end
`endif

endmodule
